event_stamp_buffer: RTL and testbench

EVENT_STAMP_BUFFER -- requirements
Module: event_stamp_buffer

---
 rtl/event_stamp_buffer.sv | 133 +++++++++++++
 tb/tb_event_stamp_buffer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/event_stamp_buffer.sv
// event_stamp_buffer
// Records stop-hit time stamps relative to a start hit. Every rising edge of
// clkEvent is a hit. The first accepted hit after reset is the start hit and
// latches the coarse count into t0. Each later accepted hit stores
// {coarse delta from t0, fine population count of the delay-line thermometer}.
// Once DEPTH stamps are held the buffer is FULL, and further hits are only
// counted as dropped. Only reset leaves FULL.
//
// Ports
//   reset      async active-high reset; clears state, flags and all entries
//   clkEvent   hit clock; each rising edge is one hit
//   en         hit acceptance enable, sampled on clkEvent
//   count      11-bit coarse count from the upstream coarse counter
//   therm      TAPS-wide thermometer code from the tapped delay line
//   rd_addr    readout index
//   rd_data    {delta[10:0], fine[4:0]} at rd_addr, or 0 beyond hit_count
//   t0         coarse count latched at the start hit
//   hit_count  number of stored stamps
//   state      IDLE=0, CAPTURE=1, FULL=2
//   full       high in FULL
//   overflow   sticky: a hit was dropped
//   dropped    dropped-hit count, saturating at 15
module event_stamp_buffer #(
    parameter int DEPTH = 8,
    parameter int TAPS  = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            reset,
    input  logic            clkEvent,
    input  logic            en,
    input  logic [10:0]     count,
    input  logic [TAPS-1:0] therm,
    input  logic [AW-1:0]   rd_addr,
    output logic [15:0]     rd_data,
    output logic [10:0]     t0,
    output logic [AW:0]     hit_count,
    output logic [1:0]      state,
    output logic            full,
    output logic            overflow,
    output logic [3:0]      dropped
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_FULL    = 2'd2,
        S_ILLEGAL = 2'd3
    } state_t;

    state_t cur_state, nxt_state;

    logic [DEPTH-1:0][15:0] entry;
    logic [10:0]            delta;
    logic [4:0]             fine;
    logic                   t0_we;
    logic                   hit_we;
    logic                   drop_hit;

    // Coarse delta wraps modulo 2048 so a start near the top of the counter
    // range still yields the correct elapsed count.
    assign delta = count - t0;

    // Population count rather than a priority encoder, so a bubble in the
    // thermometer costs at most one LSB instead of corrupting the code.
    always_comb begin
        fine = '0;
        for (int i = 0; i < TAPS; i++)
            fine = fine + 5'(therm[i]);
    end

    always_comb begin
        nxt_state = cur_state;
        t0_we     = 1'b0;
        hit_we    = 1'b0;
        drop_hit  = 1'b0;
        case (cur_state)
            S_IDLE: begin
                if (en) begin
                    t0_we     = 1'b1;
                    nxt_state = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (en) begin
                    hit_we = 1'b1;
                    // This write fills the last slot.
                    if (hit_count == (AW+1)'(DEPTH-1))
                        nxt_state = S_FULL;
                end
            end
            S_FULL: begin
                if (en)
                    drop_hit = 1'b1;
            end
            default: nxt_state = S_IDLE;  // encoding 3 is unreachable; recover on any edge
        endcase
    end

    always_ff @(posedge clkEvent or posedge reset) begin
        if (reset) begin
            cur_state <= S_IDLE;
            t0        <= '0;
            hit_count <= '0;
            overflow  <= 1'b0;
            dropped   <= '0;
            entry     <= '0;
        end else begin
            cur_state <= nxt_state;
            if (t0_we)
                t0 <= count;
            if (hit_we) begin
                entry[hit_count[AW-1:0]] <= {delta, fine};
                hit_count                <= hit_count + 1'b1;
            end
            if (drop_hit) begin
                overflow <= 1'b1;
                if (dropped != 4'hF)
                    dropped <= dropped + 1'b1;
            end
        end
    end

    // Slots at or above hit_count read as zero even if they hold stale data.
    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < hit_count)
            rd_data = entry[rd_addr];
    end

    assign state = cur_state;
    assign full  = (cur_state == S_FULL);

endmodule

// File: tb/tb_event_stamp_buffer.sv
module tb_event_stamp_buffer;

    localparam int DEPTH = 8;
    localparam int TAPS  = 16;

    logic        reset, clkEvent, en;
    logic [10:0] count;
    logic [15:0] therm;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic [10:0] t0;
    logic [3:0]  hit_count;
    logic [1:0]  state;
    logic        full, overflow;
    logic [3:0]  dropped;

    event_stamp_buffer #(.DEPTH(DEPTH), .TAPS(TAPS)) dut (
        .reset(reset), .clkEvent(clkEvent), .en(en), .count(count),
        .therm(therm), .rd_addr(rd_addr), .rd_data(rd_data), .t0(t0),
        .hit_count(hit_count), .state(state), .full(full),
        .overflow(overflow), .dropped(dropped)
    );

    initial clkEvent = 1'b0;
    always #5 clkEvent = ~clkEvent;

    typedef struct {
        int st; int hc; int t0; int ovf; int drp; int ra; int rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: list of stamps plus a phase number
    logic [15:0] m_ent[$];
    int m_st, m_t0, m_ovf, m_drp;

    function automatic void model_reset();
        m_ent.delete();
        m_st = 0; m_t0 = 0; m_ovf = 0; m_drp = 0;
    endfunction

    function automatic void model_edge(input logic e, input int c, input int th);
        int d, f;
        if (!e) return;
        if (m_st == 0) begin
            m_t0 = c;
            m_st = 1;
        end else if (m_st == 1) begin
            d = (((c - m_t0) % 2048) + 2048) % 2048;
            f = $countones(th[TAPS-1:0]);
            m_ent.push_back(16'(d * 32 + f));
            if (m_ent.size() == DEPTH) m_st = 2;
        end else begin
            m_ovf = 1;
            if (m_drp < 15) m_drp++;
        end
    endfunction

    function automatic void push_exp(input int ra);
        exp_t x;
        x.st = m_st; x.hc = m_ent.size(); x.t0 = m_t0;
        x.ovf = m_ovf; x.drp = m_drp; x.ra = ra;
        x.rd = (ra < m_ent.size()) ? int'(m_ent[ra]) : 0;
        exp_q.push_back(x);
    endfunction

    function automatic void chk(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endfunction

    // Monitor: outputs settle after each edge; compare at the falling edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clkEvent);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("state",     int'(state),     x.st);
                chk("full",      int'(full),      int'(x.st == 2));
                chk("hit_count", int'(hit_count), x.hc);
                chk("t0",        int'(t0),        x.t0);
                chk("overflow",  int'(overflow),  x.ovf);
                chk("dropped",   int'(dropped),   x.drp);
                chk($sformatf("rd_data[%0d]", x.ra), int'(rd_data), x.rd);
            end
        end
    end

    // Called 7 time units after a rising edge; returns at the same phase.
    task automatic step(input logic e, input int c, input int th, input int ra);
        en = e; count = 11'(c); therm = 16'(th); rd_addr = 3'(ra);
        @(posedge clkEvent); #1;
        model_edge(e, c, th);
        push_exp(ra);
        #6;
    endtask

    // Short asynchronous pulse between edges; the following edge has en=0.
    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
        step(1'b0, 0, 0, 0);
    endtask

    task automatic rnd_step(input logic e);
        step(e, int'($urandom_range(0, 2047)), int'($urandom & 32'hFFFF),
             int'($urandom_range(0, DEPTH-1)));
    endtask

    initial begin
        int wait_cyc;
        reset = 1'b1; en = 1'b1; count = '0; therm = '0; rd_addr = '0;
        model_reset();
        // Edges during reset with en=1 must be ignored
        repeat (2) @(posedge clkEvent);
        #1 push_exp(0);
        #6 reset = 1'b0;

        // Start then one stop: {30, 8}
        step(1'b1, 100, 'h000F, 0);
        step(1'b1, 130, 'h00FF, 0);

        // Wraparound delta, then bubbled / full-scale thermometers
        pulse_reset();
        step(1'b1, 2040, 0, 0);
        step(1'b1, 5, 0, 0);
        step(1'b1, 300, 'h00F7, 1);
        step(1'b1, 301, 'hFFFF, 2);

        // Fill with random hits and random en, then overrun the buffer
        while (m_st != 2) rnd_step(1'($urandom_range(0, 1)));
        repeat (20) rnd_step(1'b1);
        for (int a = 0; a < DEPTH; a++) step(1'b0, 0, 'hFFFF, a);

        // en=0 interleaved during capture; read beyond hit_count
        pulse_reset();
        step(1'b1, 50, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 999, 'hFFFF, 0);
            step(1'b1, 60 + k, 'h0003, k);
        end
        step(1'b0, 0, 0, 5);

        // Reset mid-capture, then a fresh start hit
        pulse_reset();
        step(1'b1, 777, 'h0001, 0);
        step(1'b1, 780, 'h0001, 0);

        // Random campaigns
        repeat (4) begin
            pulse_reset();
            repeat (30) rnd_step(1'($urandom_range(0, 3) != 0));
        end

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clkEvent);
            wait_cyc++;
        end
        n_chk++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations never compared, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
